reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
Shares the register-file write port between N_REQ writeback sources, such as the ALU, load unit and link/PC writeback. Each cycle it picks one requester round-robin and registers that request's data. It then drives a one-hot load_enable vector and a shared 32-bit write-data bus to the N_REGS reg_32_bit instances, and acknowledges the winning requester. It sits between the execute/memory stages and the register file.

Parameters:
N_REQ, 3, number of writeback requesters
N_REGS, 16, number of reg_32_bit instances in the file
ADDR_W, 4, destination register index width (log2 N_REGS)
DATA_W, 32, write data width
ZERO_REG, 1, 1 = register 0 is read-only zero; writes to it are acked but discarded

Ports:
clk  input  1  system clock, rising edge
clr  input  1  synchronous active-high reset
stall  input  1  1 = issue no new grants this edge
req  input  N_REQ  per-requester write request, held until acked
req_dest  input  N_REQ*ADDR_W  destination index; requester i occupies bits [i*ADDR_W +: ADDR_W]
req_data  input  N_REQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W]
ack  output  N_REQ  one-hot, high for exactly one cycle on grant
load_enable  output  N_REGS  one-hot write enable to reg_32_bit instances
wr_data  output  DATA_W  shared data bus to every reg_32_bit in input
busy  output  1  1 when a write is being presented this cycle (|ack)

Behaviour:
- One clock, clk. clr is synchronous and active-high. All state and all outputs are registered; nothing is driven combinationally from req.
- Reset: at a clk edge with clr=1, the following values apply:
  - ack=0, load_enable=0, wr_data=0, busy=0.
  - The round-robin pointer last_grant=N_REQ-1, so requester 0 has top priority first.
  - clr dominates stall and req.
- Eligibility at edge t: eligible[i] = req[i] & ~ack[i]. Masking the currently-acked requester prevents a double grant while it drops req.
- Grant at edge t: if stall=0 and any eligible bit is set, the winner is the first eligible index scanning last_grant+1, last_grant+2, ... modulo N_REQ.
- Registered at edge t:
  - ack <= onehot(winner).
  - wr_data <= req_data of the winner.
  - load_enable <= onehot(req_dest of the winner), or all-zero if ZERO_REG=1 and dest=0.
  - last_grant <= winner.
- If no grant at edge t: ack=0, load_enable=0, wr_data holds its previous value, last_grant unchanged.
- Latency: a request present at edge t is written into the target reg_32_bit at edge t+1, in the cycle where ack is high.
- Throughput: one write per cycle when different requesters alternate. A single requester issuing back-to-back writes gets at most every other cycle.
- Requester contract: keep req, dest and data stable until ack is seen. Drop req, or present the next request, at the edge that ends the ack cycle.
- stall=1 blocks new grants only. A grant already registered still completes its write in the current cycle.
- clr asserted while a write is being presented: load_enable is already driven for that cycle, so that write completes. The arbiter clears at the edge and does not ack the cycle after.
- Invariants:
  - popcount(ack) <= 1.
  - popcount(load_enable) <= 1.
  - load_enable != 0 implies ack != 0.

Decomposition:
- Shared header reg_defs.vh holds DATA_W=32, N_REGS=16, ADDR_W=4 and the ZERO_REG default. The register file and the decoder use the same values.
- One sub-module, rr_pick: purely combinational.
  - Inputs: eligible[N_REQ] and last_grant.
  - Outputs: winner index and a valid bit.
- The arbiter itself holds last_grant, the output registers and the dest decoder.

Test Plan:
- Reset: clr=1 for 1 edge with req=3'b111 -> ack=0, load_enable=0, wr_data=0. The first grant after clr drops is requester 0.
- Single write: req0 with dest=5, data=32'h0000000A at edge t -> at t+1, ack=3'b001, load_enable=16'h0020, wr_data=32'h0000000A. reg5 out=32'h0000000A after edge t+2.
- Round-robin fairness: req=3'b111 held with re-requests -> grant order 0,1,2,0,1,2. Each ack is one cycle wide and there is never a double ack.
- Zero register: req1 with dest=0, data=32'hDEADBEEF -> ack=3'b010, load_enable=0, reg0 unchanged.
- Stall: req2 pending with stall=1 for 3 edges -> no ack. At stall=0, ack=3'b100 at the next edge. A grant issued the edge before stall rose still completes its write.
- Reset mid-write: clr=1 during the cycle presenting ack=3'b001 -> that write lands. The next cycle has ack=0, load_enable=0, and the pointer is reset to N_REQ-1.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
// The register file and the destination decoder take their widths from here,
// so every consumer agrees on DATA_W / N_REGS / ADDR_W.
package reg_write_arbiter_pkg;

    localparam int  N_REQ            = 3;   // writeback requesters
    localparam int  N_REGS           = 16;  // reg_32_bit instances
    localparam int  ADDR_W           = 4;   // log2(N_REGS)
    localparam int  DATA_W           = 32;  // write data width
    localparam bit  ZERO_REG_DEFAULT = 1'b1;
    localparam int  REQ_IDX_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Index reached by stepping 'offset' places past 'base', wrapping at N_REQ.
    // N_REQ need not be a power of two, so the wrap is an explicit modulo.
    function automatic logic [REQ_IDX_W-1:0] rr_index(
        input logic [REQ_IDX_W-1:0] base,
        input int unsigned          offset
    );
        int unsigned sum;
        sum = int'(base) + offset;
        return REQ_IDX_W'(sum % N_REQ);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Write-port bus between the writeback requesters and the arbiter.
//   master : requester side  - drives stall, req, req_dest, req_data
//   slave  : arbiter side    - drives ack, load_enable, wr_data, busy
// Requester i occupies req_dest[i*ADDR_W +: ADDR_W] and req_data[i*DATA_W +: DATA_W].
interface reg_write_arbiter_if;
    import reg_write_arbiter_pkg::*;

    logic                      stall;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*ADDR_W-1:0]   req_dest;
    logic [N_REQ*DATA_W-1:0]   req_data;
    logic [N_REQ-1:0]          ack;
    logic [N_REGS-1:0]         load_enable;
    logic [DATA_W-1:0]         wr_data;
    logic                      busy;

    modport master (
        output stall, req, req_dest, req_data,
        input  ack, load_enable, wr_data, busy
    );

    modport slave (
        input  stall, req, req_dest, req_data,
        output ack, load_enable, wr_data, busy
    );
endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   eligible   : requesters that may be granted this edge
//   last_grant : index granted most recently
//   winner     : first eligible index after last_grant (wrapping)
//   valid      : 1 when any requester is eligible
module reg_write_arbiter_rr_pick
    import reg_write_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0]     eligible,
    input  logic [REQ_IDX_W-1:0] last_grant,
    output logic [REQ_IDX_W-1:0] winner,
    output logic                 valid
);
    // cand[k] is the index at priority rank k (rank 0 = just after last_grant).
    logic [REQ_IDX_W-1:0] cand [N_REQ];
    logic [N_REQ-1:0]     cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rank
            assign cand[gi]     = rr_index(last_grant, gi + 1);
            assign cand_hit[gi] = eligible[cand[gi]];
        end
    endgenerate

    // Scan from lowest priority upwards so the highest-priority hit is the one left standing.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                valid  = 1'b1;
                winner = cand[k];
            end
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter. Picks one writeback requester per cycle
// round-robin and presents its write, fully registered, on the next cycle.
//   clk : rising-edge clock
//   clr : synchronous active-high reset (dominates stall and req)
//   bus : slave side of reg_write_arbiter_if (req/dest/data/stall in;
//         ack, one-hot load_enable, shared wr_data, busy out)
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter bit ZERO_REG = ZERO_REG_DEFAULT
)(
    input  logic               clk,
    input  logic               clr,
    reg_write_arbiter_if.slave bus
);
    logic [N_REQ-1:0]     ack_reg;
    logic [N_REGS-1:0]    load_enable_reg;
    logic [DATA_W-1:0]    wr_data_reg;
    logic                 busy_reg;
    logic [REQ_IDX_W-1:0] last_grant_reg;

    logic [N_REQ-1:0]     eligible;
    logic [REQ_IDX_W-1:0] winner;
    logic                 pick_valid;
    logic                 grant;
    logic [ADDR_W-1:0]    dest_arr [N_REQ];
    logic [DATA_W-1:0]    data_arr [N_REQ];
    logic [ADDR_W-1:0]    win_dest;
    logic [DATA_W-1:0]    win_data;
    logic [N_REQ-1:0]     ack_next;
    logic [N_REGS-1:0]    load_enable_next;

    // The requester being acked this cycle still holds req; masking it stops a
    // second grant for the same write.
    assign eligible = bus.req & ~ack_reg;

    reg_write_arbiter_rr_pick u_pick (
        .eligible   (eligible),
        .last_grant (last_grant_reg),
        .winner     (winner),
        .valid      (pick_valid)
    );

    assign grant = pick_valid & ~bus.stall;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign dest_arr[gi] = bus.req_dest[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
            assign ack_next[gi] = (winner == REQ_IDX_W'(gi));
        end
        // Destination decoder; register 0 is never enabled when it is hardwired zero.
        for (gi = 0; gi < N_REGS; gi++) begin : g_dec
            assign load_enable_next[gi] = (win_dest == ADDR_W'(gi)) && !(ZERO_REG && (gi == 0));
        end
    endgenerate

    assign win_dest = dest_arr[winner];
    assign win_data = data_arr[winner];

    always_ff @(posedge clk) begin
        if (clr) begin
            ack_reg         <= '0;
            load_enable_reg <= '0;
            wr_data_reg     <= '0;
            busy_reg        <= 1'b0;
            last_grant_reg  <= REQ_IDX_W'(N_REQ - 1);
        end else if (grant) begin
            ack_reg         <= ack_next;
            load_enable_reg <= load_enable_next;
            wr_data_reg     <= win_data;
            busy_reg        <= 1'b1;
            last_grant_reg  <= winner;
        end else begin
            // wr_data and last_grant intentionally hold.
            ack_reg         <= '0;
            load_enable_reg <= '0;
            busy_reg        <= 1'b0;
        end
    end

    assign bus.ack         = ack_reg;
    assign bus.load_enable = load_enable_reg;
    assign bus.wr_data     = wr_data_reg;
    assign bus.busy        = busy_reg;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a small register-file model
// standing in for the reg_32_bit instances.
module tb_reg_write_arbiter;
    import reg_write_arbiter_pkg::*;

    logic clk = 1'b0;
    logic clr;
    int   checks   = 0;
    int   failures = 0;

    reg_write_arbiter_if bus();

    reg_write_arbiter dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register file model: captures wr_data into every enabled register.
    logic [31:0] rf [16] = '{default: 32'h0};
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++)
            if (bus.load_enable[i]) rf[i] <= bus.wr_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-12s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic [3:0] dest, input logic [31:0] data);
        bus.req_dest[i*ADDR_W +: ADDR_W] = dest;
        bus.req_data[i*DATA_W +: DATA_W] = data;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] a, input logic [15:0] le,
                           input logic [31:0] wd, input logic b);
        chk({tag, "_ack"},  32'(bus.ack),         32'(a));
        chk({tag, "_le"},   32'(bus.load_enable), 32'(le));
        chk({tag, "_wd"},   bus.wr_data,          wd);
        chk({tag, "_busy"}, 32'(bus.busy),        32'(b));
    endtask

    initial begin
        clr          = 1'b1;
        bus.stall    = 1'b0;
        bus.req      = 3'b111;
        bus.req_dest = '0;
        bus.req_data = '0;
        set_req(0, 4'd1, 32'h11);
        set_req(1, 4'd2, 32'h22);
        set_req(2, 4'd3, 32'h33);

        // Reset with all requesters asking
        step();
        chk_out("reset", 3'b000, 16'h0000, 32'h0, 1'b0);

        // Fairness: all three held, expect 0,1,2,0,1,2
        clr = 1'b0;
        step(); chk_out("rr0", 3'b001, 16'h0002, 32'h11, 1'b1);
        step(); chk_out("rr1", 3'b010, 16'h0004, 32'h22, 1'b1);
        step(); chk_out("rr2", 3'b100, 16'h0008, 32'h33, 1'b1);
        step(); chk_out("rr3", 3'b001, 16'h0002, 32'h11, 1'b1);
        step(); chk_out("rr4", 3'b010, 16'h0004, 32'h22, 1'b1);
        step(); chk_out("rr5", 3'b100, 16'h0008, 32'h33, 1'b1);
        bus.req = 3'b000;
        step(); chk_out("idle", 3'b000, 16'h0000, 32'h33, 1'b0);
        chk("rf3", rf[3], 32'h33);

        // Single write: req0 -> reg5
        set_req(0, 4'd5, 32'h0000000A);
        bus.req = 3'b001;
        step(); chk_out("single", 3'b001, 16'h0020, 32'h0000000A, 1'b1);
        bus.req = 3'b000;
        step(); chk("single_ack0", 32'(bus.ack), 32'h0);
        chk("rf5", rf[5], 32'h0000000A);

        // Zero register: req1 -> reg0 acked but not written
        set_req(1, 4'd0, 32'hDEADBEEF);
        bus.req = 3'b010;
        step(); chk_out("zero", 3'b010, 16'h0000, 32'hDEADBEEF, 1'b1);
        bus.req = 3'b000;
        step(); chk("zero_ack0", 32'(bus.ack), 32'h0);
        chk("rf0", rf[0], 32'h0);

        // Stall: req2 held off for three edges
        set_req(2, 4'd7, 32'h77);
        bus.req   = 3'b100;
        bus.stall = 1'b1;
        step(); chk("stall1_ack", 32'(bus.ack), 32'h0);
        step(); chk("stall2_ack", 32'(bus.ack), 32'h0);
        step(); chk("stall3_ack", 32'(bus.ack), 32'h0);
        bus.stall = 1'b0;
        step(); chk_out("unstall", 3'b100, 16'h0080, 32'h77, 1'b1);
        // Grant just before stall rises still completes
        set_req(0, 4'd9, 32'h99);
        bus.req = 3'b001;
        step(); chk_out("prestall", 3'b001, 16'h0200, 32'h99, 1'b1);
        bus.req   = 3'b000;
        bus.stall = 1'b1;
        step(); chk("stalled_ack", 32'(bus.ack), 32'h0);
        chk("rf9", rf[9], 32'h99);
        chk("rf7", rf[7], 32'h77);
        bus.stall = 1'b0;

        // Reset mid-write: last_grant=0, so req0 wins after scanning 1,2
        set_req(0, 4'd4, 32'h44);
        bus.req = 3'b001;
        step(); chk_out("prerst", 3'b001, 16'h0010, 32'h44, 1'b1);
        set_req(1, 4'd6, 32'h66);
        bus.req = 3'b011;
        clr     = 1'b1;
        step(); chk_out("midrst", 3'b000, 16'h0000, 32'h0, 1'b0);
        chk("rf4", rf[4], 32'h44);
        // Pointer back at N_REQ-1: requester 0 beats requester 1
        clr = 1'b0;
        step(); chk_out("postrst", 3'b001, 16'h0010, 32'h44, 1'b1);
        bus.req = 3'b010;
        step(); chk_out("postrst2", 3'b010, 16'h0040, 32'h66, 1'b1);
        bus.req = 3'b000;
        step(); chk("final_ack", 32'(bus.ack), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
